// File: rtl/asic_config_loader_pkg.sv
// Shared types and constants for the ASIC configuration loader.
package asic_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int SIZESRSTAT_DEF = 88;
   localparam int SIZESRDYN_DEF  = 16;

   localparam logic [3:0] ADDR_STAT_LAST = 4'd10;
   localparam logic [3:0] ADDR_DYN_HI    = 4'd11;
   localparam logic [3:0] ADDR_DYN_LO    = 4'd12;

endpackage

// File: rtl/asic_config_loader_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the async level through STAGES flops; only the last one is used.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/asic_config_loader.sv
// Host-written static/dynamic image store and load sequencer for the
// 2 MHz configuration serializer.
module asic_config_loader
   import asic_cfg_pkg::*;
#(
   parameter int                    SIZESRSTAT     = SIZESRSTAT_DEF,
   parameter int                    SIZESRDYN      = SIZESRDYN_DEF,
   parameter logic [SIZESRSTAT-1:0] STAT_RST       = '0,
   parameter logic [SIZESRDYN-1:0]  DYN_RST        = '0,
   parameter int                    SYNC_STAGES    = 2,
   parameter int                    TIMEOUT_CYCLES = 65535
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  wr_en,
   input  logic [3:0]            wr_addr,
   input  logic [7:0]            wr_data,
   output logic                  wr_rejected,
   input  logic                  go,
   input  logic                  go_static,
   input  logic                  go_dyn,
   output logic                  busy,
   output logic                  done,
   output logic                  err_timeout,
   output logic [SIZESRSTAT-1:0] static_conf_ear,
   output logic [SIZESRDYN-1:0]  dynamic_conf,
   output logic                  flag_stat,
   output logic                  flag_dyn,
   output logic                  start_ASIC_config,
   input  logic                  end_config
);

   localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e                  state_q, state_d;
   logic                    pend_stat_q, pend_stat_d;
   logic                    pend_dyn_q, pend_dyn_d;
   // armed_q=0 in REQ means end_s was still high on entry (stale END):
   // keep the serializer released until it drops, then raise the flag.
   logic                    armed_q, armed_d;
   logic                    err_q, err_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic [SIZESRSTAT-1:0]   stat_q, stat_d;
   logic [SIZESRDYN-1:0]    dyn_q, dyn_d;
   logic                    wr_rej_q, wr_rej_d;
   logic                    end_s;

   sync_bit #(.STAGES(SYNC_STAGES)) u_end_sync (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (end_config),
      .q_o   (end_s)
   );

   // Byte writes into the shadow images; only honoured while idle.
   always_comb begin
      stat_d   = stat_q;
      dyn_d    = dyn_q;
      wr_rej_d = 1'b0;
      if (wr_en) begin
         if (state_q == IDLE && wr_addr <= ADDR_DYN_LO) begin
            for (int i = 0; i <= int'(ADDR_STAT_LAST); i++) begin
               if (wr_addr == 4'(i)) stat_d[SIZESRSTAT-1-8*i -: 8] = wr_data;
            end
            if (wr_addr == ADDR_DYN_HI) dyn_d[SIZESRDYN-1 -: 8] = wr_data;
            if (wr_addr == ADDR_DYN_LO) dyn_d[7:0] = wr_data;
         end else begin
            wr_rej_d = 1'b1;
         end
      end
   end

   // Load sequencer: next state, pending bits, timeout counter and outputs.
   always_comb begin
      state_d           = state_q;
      pend_stat_d       = pend_stat_q;
      pend_dyn_d        = pend_dyn_q;
      armed_d           = armed_q;
      err_d             = err_q;
      tmo_d             = '0;
      flag_stat         = 1'b0;
      flag_dyn          = 1'b0;
      start_ASIC_config = 1'b0;
      busy              = 1'b0;
      done              = 1'b0;
      case (state_q)
         IDLE: begin
            if (go && (go_static || go_dyn)) begin
               pend_stat_d = go_static;
               pend_dyn_d  = go_dyn;
               err_d       = 1'b0;
               armed_d     = !end_s;
               state_d     = REQ;
            end
         end
         REQ: begin
            busy  = 1'b1;
            tmo_d = tmo_q + 1'b1;
            if (armed_q) begin
               // Static has priority; exactly one flag at a time.
               flag_stat = pend_stat_q;
               flag_dyn  = !pend_stat_q && pend_dyn_q;
               if (end_s) begin
                  if (pend_stat_q) pend_stat_d = 1'b0;
                  else             pend_dyn_d  = 1'b0;
                  state_d = REL;
                  tmo_d   = '0;
               end
            end else begin
               start_ASIC_config = 1'b1;
               if (!end_s) armed_d = 1'b1;
            end
         end
         REL: begin
            busy              = 1'b1;
            start_ASIC_config = 1'b1;
            tmo_d             = tmo_q + 1'b1;
            if (!end_s) begin
               tmo_d = '0;
               // Next flag goes up on this same edge: no idle gap allowed.
               if (pend_stat_q || pend_dyn_q) begin
                  state_d = REQ;
                  armed_d = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Serializer stopped answering: abandon the sequence without done.
      if ((state_q == REQ || state_q == REL) && tmo_q == TMO_LAST) begin
         err_d       = 1'b1;
         pend_stat_d = 1'b0;
         pend_dyn_d  = 1'b0;
         state_d     = IDLE;
         tmo_d       = '0;
      end
   end

   // State, image and status registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         pend_stat_q <= 1'b0;
         pend_dyn_q  <= 1'b0;
         armed_q     <= 1'b0;
         err_q       <= 1'b0;
         tmo_q       <= '0;
         stat_q      <= STAT_RST;
         dyn_q       <= DYN_RST;
         wr_rej_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_stat_q <= pend_stat_d;
         pend_dyn_q  <= pend_dyn_d;
         armed_q     <= armed_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
         stat_q      <= stat_d;
         dyn_q       <= dyn_d;
         wr_rej_q    <= wr_rej_d;
      end
   end

   assign static_conf_ear = stat_q;
   assign dynamic_conf    = dyn_q;
   assign err_timeout     = err_q;
   assign wr_rejected     = wr_rej_q;

endmodule

// File: tb/tb_asic_config_loader.sv
// Directed bench for asic_config_loader with a hand-driven serializer.
module tb_asic_config_loader;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        wr_rejected;
   logic        go = 1'b0, go_static = 1'b0, go_dyn = 1'b0;
   logic        busy, done, err_timeout;
   logic [87:0] static_conf_ear;
   logic [15:0] dynamic_conf;
   logic        flag_stat, flag_dyn, start_ASIC_config;
   logic        end_config = 1'b0;

   localparam logic [87:0] IMG_S = 88'hA0A1A2A3A4A5A6A7A8A9AA;
   localparam logic [15:0] IMG_D = 16'hABAC;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int both_hi  = 0;
   int stat_hi  = 0;
   int done_n   = 0;
   int rej_n    = 0;

   asic_config_loader #(.TIMEOUT_CYCLES(100)) dut (
      .CLK               (CLK),
      .RST               (RST),
      .wr_en             (wr_en),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .wr_rejected       (wr_rejected),
      .go                (go),
      .go_static         (go_static),
      .go_dyn            (go_dyn),
      .busy              (busy),
      .done              (done),
      .err_timeout       (err_timeout),
      .static_conf_ear   (static_conf_ear),
      .dynamic_conf      (dynamic_conf),
      .flag_stat         (flag_stat),
      .flag_dyn          (flag_dyn),
      .start_ASIC_config (start_ASIC_config),
      .end_config        (end_config)
   );

   always #5 CLK = ~CLK;

   // Event counters over the whole run.
   always @(posedge CLK) begin
      if (flag_stat && flag_dyn) both_hi <= both_hi + 1;
      if (flag_stat)             stat_hi <= stat_hi + 1;
      if (done)                  done_n  <= done_n + 1;
      if (wr_rejected)           rej_n   <= rej_n + 1;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr_byte(input logic [3:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_go(input logic s, input logic dy);
      go = 1'b1; go_static = s; go_dyn = dy;
      tick();
      go = 1'b0; go_static = 1'b0; go_dyn = 1'b0;
   endtask

   // Bounded wait for start_ASIC_config to reach lvl; n = edges taken.
   task automatic wait_start(input logic lvl, output int n);
      n = 0;
      while (start_ASIC_config !== lvl && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      #1;
      chk_cnt++;
      if ({busy, done, err_timeout, flag_stat, flag_dyn, start_ASIC_config, wr_rejected} !== 7'b0) begin
         $display("FAIL reset_outputs: got %b required 0000000", {busy, done, err_timeout, flag_stat, flag_dyn, start_ASIC_config, wr_rejected});
      end else pass_cnt++;
      chk_cnt++;
      if (static_conf_ear !== 88'h0 || dynamic_conf !== 16'h0) begin
         $display("FAIL reset_images: got %h/%h required 0/0", static_conf_ear, dynamic_conf);
      end else pass_cnt++;
      repeat (3) tick();
      RST = 1'b0;
      tick();
   endtask

   task automatic test_write();
      int r0;
      r0 = rej_n;
      for (int i = 0; i <= 12; i++) wr_byte(4'(i), 8'(8'hA0 + i));
      tick();
      chk_cnt++;
      if (static_conf_ear !== IMG_S) begin
         $display("FAIL write_static: got %h required %h", static_conf_ear, IMG_S);
      end else pass_cnt++;
      chk_cnt++;
      if (dynamic_conf !== IMG_D) begin
         $display("FAIL write_dyn: got %h required %h", dynamic_conf, IMG_D);
      end else pass_cnt++;
      chk_cnt++;
      if (rej_n - r0 !== 0) begin
         $display("FAIL write_no_reject: got %0d rejects required 0", rej_n - r0);
      end else pass_cnt++;
   endtask

   task automatic test_both();
      int n, d0, b0;
      d0 = done_n; b0 = both_hi;
      pulse_go(1'b1, 1'b1);
      chk_cnt++;
      if ({busy, flag_stat, flag_dyn, start_ASIC_config} !== 4'b1100) begin
         $display("FAIL both_req_stat: got %b required 1100", {busy, flag_stat, flag_dyn, start_ASIC_config});
      end else pass_cnt++;
      end_config = 1'b1;
      wait_start(1'b1, n);
      chk_cnt++;
      if (n !== 3 || {flag_stat, flag_dyn} !== 2'b00) begin
         $display("FAIL both_rel_lat: got %0d cycles flags %b required 3 cycles flags 00", n, {flag_stat, flag_dyn});
      end else pass_cnt++;
      end_config = 1'b0;
      wait_start(1'b0, n);
      chk_cnt++;
      if (n !== 3 || {flag_stat, flag_dyn} !== 2'b01) begin
         $display("FAIL both_dyn_no_gap: got %0d cycles flags %b required 3 cycles flags 01", n, {flag_stat, flag_dyn});
      end else pass_cnt++;
      end_config = 1'b1;
      wait_start(1'b1, n);
      end_config = 1'b0;
      wait_start(1'b0, n);
      chk_cnt++;
      if ({done, busy} !== 2'b10) begin
         $display("FAIL both_done: got done/busy %b required 10", {done, busy});
      end else pass_cnt++;
      tick();
      chk_cnt++;
      if (done_n - d0 !== 1 || both_hi - b0 !== 0 || done !== 1'b0) begin
         $display("FAIL both_once: got %0d dones %0d overlaps required 1 and 0", done_n - d0, both_hi - b0);
      end else pass_cnt++;
   endtask

   task automatic test_dyn_only();
      int n, s0;
      s0 = stat_hi;
      pulse_go(1'b0, 1'b1);
      chk_cnt++;
      if ({flag_stat, flag_dyn} !== 2'b01) begin
         $display("FAIL dyn_only_flag: got %b required 01", {flag_stat, flag_dyn});
      end else pass_cnt++;
      end_config = 1'b1;
      wait_start(1'b1, n);
      end_config = 1'b0;
      wait_start(1'b0, n);
      chk_cnt++;
      if (n !== 3 || done !== 1'b1) begin
         $display("FAIL dyn_only_done: got %0d cycles done %b required 3 cycles done 1", n, done);
      end else pass_cnt++;
      tick();
      chk_cnt++;
      if (stat_hi - s0 !== 0) begin
         $display("FAIL dyn_only_no_stat: got %0d stat cycles required 0", stat_hi - s0);
      end else pass_cnt++;
   endtask

   task automatic test_reject();
      int n, d0;
      pulse_go(1'b1, 1'b0);
      wr_byte(4'd3, 8'h55);
      chk_cnt++;
      if (wr_rejected !== 1'b1 || static_conf_ear !== IMG_S) begin
         $display("FAIL busy_write_reject: got rej %b img %h required 1 %h", wr_rejected, static_conf_ear, IMG_S);
      end else pass_cnt++;
      tick();
      chk_cnt++;
      if (wr_rejected !== 1'b0) begin
         $display("FAIL reject_pulse: got %b required 0", wr_rejected);
      end else pass_cnt++;
      pulse_go(1'b0, 1'b1);
      end_config = 1'b1;
      wait_start(1'b1, n);
      end_config = 1'b0;
      wait_start(1'b0, n);
      chk_cnt++;
      if (done !== 1'b1 || flag_dyn !== 1'b0) begin
         $display("FAIL go_while_busy: got done %b flag_dyn %b required 1 0", done, flag_dyn);
      end else pass_cnt++;
      tick();
      wr_byte(4'd13, 8'h55);
      chk_cnt++;
      if (wr_rejected !== 1'b1 || static_conf_ear !== IMG_S || dynamic_conf !== IMG_D) begin
         $display("FAIL addr13_reject: got rej %b img %h/%h required 1 %h/%h", wr_rejected, static_conf_ear, dynamic_conf, IMG_S, IMG_D);
      end else pass_cnt++;
      d0 = done_n;
      pulse_go(1'b0, 1'b0);
      tick();
      tick();
      chk_cnt++;
      if (busy !== 1'b0 || done_n - d0 !== 0) begin
         $display("FAIL go_no_select: got busy %b dones %0d required 0 0", busy, done_n - d0);
      end else pass_cnt++;
   endtask

   task automatic test_timeout();
      int n, d0;
      d0 = done_n;
      pulse_go(1'b1, 1'b0);
      n = 0;
      while (err_timeout !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk_cnt++;
      if (n !== 100) begin
         $display("FAIL timeout_cycle: got %0d required 100", n);
      end else pass_cnt++;
      chk_cnt++;
      if ({busy, flag_stat, flag_dyn, start_ASIC_config, done} !== 5'b0) begin
         $display("FAIL timeout_outputs: got %b required 00000", {busy, flag_stat, flag_dyn, start_ASIC_config, done});
      end else pass_cnt++;
      tick();
      chk_cnt++;
      if (done_n - d0 !== 0 || err_timeout !== 1'b1) begin
         $display("FAIL timeout_sticky: got dones %0d err %b required 0 1", done_n - d0, err_timeout);
      end else pass_cnt++;
      pulse_go(1'b0, 1'b1);
      chk_cnt++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL timeout_clear: got err %b busy %b required 0 1", err_timeout, busy);
      end else pass_cnt++;
      end_config = 1'b1;
      wait_start(1'b1, n);
      end_config = 1'b0;
      wait_start(1'b0, n);
      tick();
   endtask

   task automatic test_stale();
      int n;
      end_config = 1'b1;
      repeat (4) tick();
      pulse_go(1'b1, 1'b0);
      chk_cnt++;
      if ({busy, flag_stat, flag_dyn, start_ASIC_config} !== 4'b1001) begin
         $display("FAIL stale_hold: got %b required 1001", {busy, flag_stat, flag_dyn, start_ASIC_config});
      end else pass_cnt++;
      end_config = 1'b0;
      n = 0;
      while (flag_stat !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk_cnt++;
      if (n !== 3 || start_ASIC_config !== 1'b0) begin
         $display("FAIL stale_arm: got %0d cycles start %b required 3 0", n, start_ASIC_config);
      end else pass_cnt++;
      end_config = 1'b1;
      wait_start(1'b1, n);
      end_config = 1'b0;
      wait_start(1'b0, n);
      chk_cnt++;
      if (done !== 1'b1) begin
         $display("FAIL stale_done: got %b required 1", done);
      end else pass_cnt++;
      tick();
   endtask

   task automatic test_rst_mid();
      int n;
      pulse_go(1'b1, 1'b0);
      end_config = 1'b1;
      wait_start(1'b1, n);
      @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk_cnt++;
      if ({start_ASIC_config, flag_stat, flag_dyn, busy} !== 4'b0) begin
         $display("FAIL rst_async_outputs: got %b required 0000", {start_ASIC_config, flag_stat, flag_dyn, busy});
      end else pass_cnt++;
      chk_cnt++;
      if (static_conf_ear !== 88'h0 || dynamic_conf !== 16'h0) begin
         $display("FAIL rst_images: got %h/%h required 0/0", static_conf_ear, dynamic_conf);
      end else pass_cnt++;
      end_config = 1'b0;
      tick();
      RST = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_both();
      test_dyn_only();
      test_reject();
      test_timeout();
      test_stale();
      test_rst_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
